keyboard_matrix: RTL and testbench

Host-side key-state store feeding the emulated keyboard matrix read path. Accepts make/break events through a valid/ready handshake and buffers them in a small FIFO. Applies them to an 8x8 key-state array no faster than one per `EVENT_GAP` cycles, so the emulated CPU's row scan sees every transition. Returns active-low column data for the row chosen by the upstream priority encoder (`SELECTED_ROW`).

---
 rtl/keyboard_matrix.sv | 145 ++++++++++++++
 tb/tb_keyboard_matrix.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_matrix.sv
// keyboard_matrix
// Host-side key-state store for the emulated keyboard matrix read path.
// Make/break events arrive through a valid/ready handshake and are buffered
// in a small FIFO. They are applied to an 8x8 key-state array no faster than
// one per EVENT_GAP cycles, so the emulated CPU's row scan sees every
// transition. The read path returns registered, active-low column data for
// the selected row.
//
// Parameters:
//   FIFO_DEPTH   event FIFO entries (power of two, >= 2)
//   EVENT_GAP    minimum cycles between successive applied events (>= 1)
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous reset, active-high
//   EV_VALID     event offered
//   EV_READY     event FIFO can accept
//   EV_ROW       key row of the offered event
//   EV_COL       key column of the offered event
//   EV_MAKE      1 = press, 0 = release
//   CLEAR_ALL    synchronous flush: empty FIFO, release all keys
//   SELECTED_ROW row index from the matrix encoder
//   ROW_ACTIVE   1 when any row strobe is asserted
//   COL_DATA     registered active-low column bits for the selected row
//   PENDING      FIFO non-empty or gap timer running
module keyboard_matrix #(
   parameter int FIFO_DEPTH = 4,
   parameter int EVENT_GAP  = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EV_VALID,
   output logic       EV_READY,
   input  logic [2:0] EV_ROW,
   input  logic [2:0] EV_COL,
   input  logic       EV_MAKE,
   input  logic       CLEAR_ALL,
   input  logic [2:0] SELECTED_ROW,
   input  logic       ROW_ACTIVE,
   output logic [7:0] COL_DATA,
   output logic       PENDING
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (EVENT_GAP > 1) ? $clog2(EVENT_GAP) : 1;

   typedef enum logic {IDLE, GAP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   // Pointers carry one extra bit so full and empty are distinguishable.
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [6:0]    fifo_mem [FIFO_DEPTH];
   logic [6:0]    head;
   logic          full, empty, push, pop;

   logic [7:0]    key [8];

   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign EV_READY = !full && !CLEAR_ALL && !RST;
   assign push     = EV_VALID && EV_READY;
   assign head     = fifo_mem[rd_ptr[AW-1:0]];
   assign PENDING  = !empty || (state == GAP);

   // FIFO storage holds data only; validity is tracked by the pointers.
   always_ff @(posedge CLK) begin
      if (push)
         fifo_mem[wr_ptr[AW-1:0]] <= {EV_ROW, EV_COL, EV_MAKE};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (CLEAR_ALL) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The counter is loaded with EVENT_GAP-1 at the pop and GAP is left on the
   // edge where it reaches 0, so the next pop lands exactly EVENT_GAP edges
   // after the previous one. A freshly pushed entry is never popped on the
   // same edge because the pop only looks at the pre-edge FIFO contents.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pop       = 1'b0;
      if (CLEAR_ALL) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  pop       = 1'b1;
                  cnt_nxt   = CW'(EVENT_GAP - 1);
                  state_nxt = (EVENT_GAP > 1) ? GAP : IDLE;
               end
            end
            GAP: begin
               cnt_nxt = cnt - 1'b1;
               if (cnt == CW'(1))
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         key <= '{default: '0};
      else if (CLEAR_ALL)
         key <= '{default: '0};
      else if (pop)
         key[head[6:4]][head[3:1]] <= head[0];
   end

   // Samples the array before this edge's update, so a newly applied event
   // shows up on the read path one edge after it is written.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         COL_DATA <= 8'hFF;
      else
         COL_DATA <= ROW_ACTIVE ? ~key[SELECTED_ROW] : 8'hFF;
   end

endmodule

// File: tb/tb_keyboard_matrix.sv
// tb_keyboard_matrix
// Self-checking bench for keyboard_matrix. A behavioural model (event queue,
// key bitmap, cycles-until-next-apply counter) predicts COL_DATA, PENDING and
// EV_READY every cycle; directed sequences pin the model with literal values.
module tb_keyboard_matrix;

   localparam int DEPTH = 4;
   localparam int GAP   = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       EV_VALID = 1'b0;
   logic       EV_MAKE = 1'b0;
   logic       CLEAR_ALL = 1'b0;
   logic       ROW_ACTIVE = 1'b0;
   logic [2:0] EV_ROW = '0;
   logic [2:0] EV_COL = '0;
   logic [2:0] SELECTED_ROW = '0;
   logic       EV_READY;
   logic       PENDING;
   logic [7:0] COL_DATA;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [6:0] mq[$];
   bit   [7:0] mkey [8];
   int         mgap = 0;
   logic [7:0] mcol = 8'hFF;

   keyboard_matrix #(.FIFO_DEPTH(DEPTH), .EVENT_GAP(GAP)) dut (
      .CLK(CLK), .RST(RST), .EV_VALID(EV_VALID), .EV_READY(EV_READY),
      .EV_ROW(EV_ROW), .EV_COL(EV_COL), .EV_MAKE(EV_MAKE),
      .CLEAR_ALL(CLEAR_ALL), .SELECTED_ROW(SELECTED_ROW),
      .ROW_ACTIVE(ROW_ACTIVE), .COL_DATA(COL_DATA), .PENDING(PENDING)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Behavioural model: one event may be applied when the spacing counter is
   // zero; applying reloads it so the next apply is GAP edges later.
   initial begin
      logic [6:0] ev;
      bit         acc;
      forever begin
         @(posedge CLK or posedge RST);
         if (RST) begin
            mq.delete();
            foreach (mkey[i]) mkey[i] = '0;
            mgap = 0;
            mcol = 8'hFF;
         end else begin
            acc  = EV_VALID && (mq.size() < DEPTH) && !CLEAR_ALL;
            mcol = ROW_ACTIVE ? ~mkey[SELECTED_ROW] : 8'hFF;
            if (CLEAR_ALL) begin
               mq.delete();
               foreach (mkey[i]) mkey[i] = '0;
               mgap = 0;
            end else begin
               if (mgap == 0 && mq.size() > 0) begin
                  ev = mq.pop_front();
                  mkey[ev[6:4]][ev[3:1]] = ev[0];
                  mgap = GAP - 1;
               end else if (mgap > 0) begin
                  mgap--;
               end
               if (acc)
                  mq.push_back({EV_ROW, EV_COL, EV_MAKE});
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         chk("col_data", COL_DATA, mcol);
         chk("pending", {7'd0, PENDING}, {7'd0, (mq.size() > 0) || (mgap > 0)});
         chk("ev_ready", {7'd0, EV_READY}, {7'd0, (mq.size() < DEPTH) && !CLEAR_ALL && !RST});
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic offer(input int r, input int c, input bit mk);
      EV_VALID = 1'b1;
      EV_ROW   = 3'(r);
      EV_COL   = 3'(c);
      EV_MAKE  = mk;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && PENDING !== 1'b0; i++)
         step();
      chk("idle_wait", {7'd0, PENDING}, 8'd0);
   endtask

   task automatic flush();
      EV_VALID  = 1'b0;
      CLEAR_ALL = 1'b1;
      step();
      CLEAR_ALL = 1'b0;
   endtask

   task automatic single_key();
      flush();
      SELECTED_ROW = 3'd2;
      ROW_ACTIVE   = 1'b1;
      offer(2, 5, 1'b1);
      step();                       // accepted at edge N
      EV_VALID = 1'b0;
      step();                       // applied at edge N+1
      chk("lat_n1", COL_DATA, 8'hFF);
      step();                       // visible at edge N+2
      chk("single_key", COL_DATA, 8'hDF);
      SELECTED_ROW = 3'd3;
      step();
      chk("other_row", COL_DATA, 8'hFF);
      SELECTED_ROW = 3'd2;
      ROW_ACTIVE   = 1'b0;
      step();
      chk("row_inactive", COL_DATA, 8'hFF);
   endtask

   initial begin
      int n;
      int k;
      int acc_at [6];

      // Reset
      #1 RST = 1'b1;
      step();
      step();
      chk("rst_col", COL_DATA, 8'hFF);
      chk("rst_pend", {7'd0, PENDING}, 8'd0);
      chk("rst_ready", {7'd0, EV_READY}, 8'd0);
      RST = 1'b0;
      #1 chk("ready_after_rst", {7'd0, EV_READY}, 8'd1);

      single_key();

      // Gap: make then break back-to-back, key reads pressed for GAP cycles
      flush();
      SELECTED_ROW = 3'd1;
      ROW_ACTIVE   = 1'b1;
      offer(1, 0, 1'b1);
      step();
      offer(1, 0, 1'b0);
      step();
      EV_VALID = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (COL_DATA == 8'hFE) n++;
      end
      chk("gap_width", 8'(n), 8'(GAP));
      chk("gap_pend_fall", {7'd0, PENDING}, 8'd0);

      // FIFO full: hold valid for 6 distinct events
      flush();
      foreach (acc_at[i]) acc_at[i] = -1;
      k = 0;
      for (int i = 0; i < 40 && k < 6; i++) begin
         offer(k, k, 1'b1);
         #1;
         if (EV_READY) begin
            acc_at[k] = i;
            k++;
         end
         step();
      end
      EV_VALID = 1'b0;
      chk("fifo_5th", 8'(acc_at[4]), 8'd4);
      chk("fifo_6th", 8'(acc_at[5]), 8'(2 + GAP));
      wait_idle();
      ROW_ACTIVE = 1'b1;
      for (int r = 0; r < 6; r++) begin
         SELECTED_ROW = 3'(r);
         step();
         chk("fifo_order_row", COL_DATA, ~(8'd1 << r));
      end

      // CLEAR_ALL with keys pressed, events queued and valid high
      flush();
      offer(0, 0, 1'b1);
      step();
      offer(7, 7, 1'b1);
      step();
      EV_VALID = 1'b0;
      wait_idle();
      offer(3, 3, 1'b1); step();
      offer(4, 4, 1'b1); step();
      offer(5, 5, 1'b1); step();
      offer(6, 6, 1'b1); step();
      offer(2, 2, 1'b1);
      CLEAR_ALL = 1'b1;
      #1 chk("clr_ready", {7'd0, EV_READY}, 8'd0);
      step();
      CLEAR_ALL = 1'b0;
      EV_VALID  = 1'b0;
      chk("clr_pending", {7'd0, PENDING}, 8'd0);
      for (int r = 0; r < 8; r++) begin
         SELECTED_ROW = 3'(r);
         step();
         chk("clr_row", COL_DATA, 8'hFF);
      end
      repeat (30) step();

      // Asynchronous reset mid-gap with an event queued
      flush();
      SELECTED_ROW = 3'd1;
      ROW_ACTIVE   = 1'b1;
      offer(1, 1, 1'b1); step();
      offer(1, 2, 1'b1); step();
      offer(1, 3, 1'b1); step();
      EV_VALID = 1'b0;
      step();
      chk("pre_rst_col", COL_DATA, 8'hFD);
      #3 RST = 1'b1;
      #1;
      chk("arst_col", COL_DATA, 8'hFF);
      chk("arst_pend", {7'd0, PENDING}, 8'd0);
      chk("arst_ready", {7'd0, EV_READY}, 8'd0);
      step();
      step();
      RST = 1'b0;
      #1 chk("arst_ready_after", {7'd0, EV_READY}, 8'd1);
      single_key();

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         EV_VALID     = 1'($urandom_range(0, 1));
         EV_ROW       = 3'($urandom_range(0, 7));
         EV_COL       = 3'($urandom_range(0, 7));
         EV_MAKE      = 1'($urandom_range(0, 1));
         SELECTED_ROW = 3'($urandom_range(0, 7));
         ROW_ACTIVE   = ($urandom_range(0, 3) != 0);
         CLEAR_ALL    = ($urandom_range(0, 59) == 0);
         step();
      end
      EV_VALID  = 1'b0;
      CLEAR_ALL = 1'b0;
      wait_idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
